// File: rtl/sdram_init_seq_pkg.sv
// Shared definitions for the SDRAM init sequencer: command and state encodings,
// mode-word bit positions and elaboration-time timing helpers.
// SDRAM_EMRS_EN adds the extended mode-register state SDINITEMRS.
package sdram_init_seq_pkg;

    // SDRAM commands as {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] NOPC       = 4'b0111;
    localparam logic [3:0] PRECHAGE   = 4'b0010;
    localparam logic [3:0] AUTOREF    = 4'b0001;
    localparam logic [3:0] MODEREGSET = 4'b0000;

    typedef enum logic [2:0] {
        SDINITSTABLE = 3'd0,
        SDINITPRECH  = 3'd1,
        SDINITAPREF  = 3'd2,
        SDINITMRS    = 3'd3,
        SDINITIDLE   = 3'd4
`ifdef SDRAM_EMRS_EN
        ,
        SDINITEMRS   = 3'd5
`endif
    } init_state_e;

    // Mode-register word bit positions
    localparam int MODE_BL_LSB = 0;
    localparam int MODE_BT_BIT = 3;
    localparam int MODE_CL_LSB = 4;
    localparam int MODE_WB_BIT = 9;
    // A10 selects all banks on PRECHARGE
    localparam int ADDR_AP_BIT = 10;
    // Bank select for the extended mode register
    localparam logic [1:0] EMRS_BA = 2'b10;

    // ceil(ns * MHz / 1000), never less than one cycle
    function automatic int ns_to_cycles(input int ns, input int mhz);
        int c;
        c = (ns * mhz + 999) / 1000;
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Low ten bits of the mode-register word
    function automatic logic [9:0] mode_word(input logic       wb,
                                             input logic [2:0] cl,
                                             input logic       bt,
                                             input logic [2:0] bl);
        logic [9:0] mw;
        mw                     = '0;
        mw[MODE_WB_BIT]        = wb;
        mw[MODE_CL_LSB +: 3]   = cl;
        mw[MODE_BT_BIT]        = bt;
        mw[MODE_BL_LSB +: 3]   = bl;
        return mw;
    endfunction

endpackage

// File: rtl/sdram_init_seq_if.sv
// SDRAM command bus plus init handshake shared between the init sequencer
// (master) and the refresh/access arbiter side (slave).
interface sdram_init_seq_if #(
    parameter int ROW_W = 13,
    parameter int BA_W  = 2
) ();
    logic             ReInit;
    logic             SdramCke;
    logic [3:0]       SdramCmd;
    logic [ROW_W-1:0] SdramAddr;
    logic [BA_W-1:0]  SdramBa;
    logic             InitBusy;
    logic             InitDone;

    modport master (
        input  ReInit,
        output SdramCke, SdramCmd, SdramAddr, SdramBa, InitBusy, InitDone
    );

    modport slave (
        output ReInit,
        input  SdramCke, SdramCmd, SdramAddr, SdramBa, InitBusy, InitDone
    );
endinterface

// File: rtl/sdram_init_seq_timer.sv
// Loadable down-counter shared by every wait phase of the init sequence.
// done is high whenever the count has reached zero; the count then holds.
module sdram_init_timer #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rest,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: load wins, otherwise count down to zero and stop
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);
endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up / re-initialisation sequencer.
// POWERUP wait -> PRECHARGE all -> REF_NUM x AUTOREF -> MODEREGSET -> DONE.
// Each command is registered for one cycle; the timer is loaded with N-1 on
// the command edge so the next command lands exactly N cycles later.
// Define SDRAM_EMRS_EN to add an extended mode-register write after MRS.
module sdram_init_seq
    import sdram_init_seq_pkg::*;
#(
    parameter int         SDRAM_MHZ    = 100,
    parameter int         T_POWERUP_US = 200,
    parameter int         T_RP_NS      = 20,
    parameter int         T_RFC_NS     = 70,
    parameter int         T_MRD_CYC    = 2,
    parameter int         REF_NUM      = 8,
    parameter int         ROW_W        = 13,
    parameter int         BA_W         = 2,
    parameter int         CAS_LAT      = 3,
    parameter logic [2:0] BURST_LEN    = 3'b000,
    parameter logic       BURST_TYPE   = 1'b0,
    parameter logic       WRITE_BURST  = 1'b0
`ifdef SDRAM_EMRS_EN
    ,
    parameter logic [ROW_W-1:0] EMRS_VALUE = '0
`endif
) (
    input logic               Clk,
    input logic               Rest,
    sdram_init_seq_if.master  bus
);
    localparam int N_PU    = T_POWERUP_US * SDRAM_MHZ;
    localparam int N_RP    = ns_to_cycles(T_RP_NS, SDRAM_MHZ);
    localparam int N_RFC   = ns_to_cycles(T_RFC_NS, SDRAM_MHZ);
    localparam int N_MRD   = T_MRD_CYC;
    localparam int MAX_CNT = max2(max2(N_PU, N_RP), max2(N_RFC, N_MRD));
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;

    // POWERUP spends one cycle raising CKE and one cycle moving to PRECH,
    // so its timer load is N_PU-3 to put PRECHARGE on cycle N_PU.
    localparam int PU_LOAD = (N_PU >= 3) ? N_PU - 3 : 0;

    localparam logic [CNT_W-1:0] PU_LOAD_C  = CNT_W'(PU_LOAD);
    localparam logic [CNT_W-1:0] RP_LOAD_C  = CNT_W'(N_RP - 1);
    localparam logic [CNT_W-1:0] RFC_LOAD_C = CNT_W'(N_RFC - 1);
    localparam logic [CNT_W-1:0] MRD_LOAD_C = CNT_W'(N_MRD - 1);

    localparam logic [3:0]       REF_LAST   = 4'(REF_NUM);
    localparam logic [ROW_W-1:0] PRECH_ADDR = ROW_W'(1 << ADDR_AP_BIT);
    localparam logic [ROW_W-1:0] MODE_ADDR  =
        ROW_W'(mode_word(WRITE_BURST, 3'(CAS_LAT), BURST_TYPE, BURST_LEN));

    init_state_e      state_q, state_d;
    logic             cke_q, cke_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [ROW_W-1:0] addr_q, addr_d;
    logic [BA_W-1:0]  ba_q, ba_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [3:0]       ref_q, ref_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;

    sdram_init_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .Clk      (Clk),
        .Rest     (Rest),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Next state, next command and timer control; NOP/zero bus unless a command fires
    always_comb begin
        state_d  = state_q;
        cke_d    = cke_q;
        cmd_d    = NOPC;
        addr_d   = '0;
        ba_d     = '0;
        busy_d   = busy_q;
        done_d   = done_q;
        ref_d    = ref_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            SDINITSTABLE: begin
                if (!cke_q) begin
                    cke_d    = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = PU_LOAD_C;
                end else if (tmr_done) begin
                    state_d = SDINITPRECH;
                end
            end
            SDINITPRECH: begin
                if (tmr_done) begin
                    cmd_d    = PRECHAGE;
                    addr_d   = PRECH_ADDR;
                    tmr_load = 1'b1;
                    tmr_val  = RP_LOAD_C;
                    state_d  = SDINITAPREF;
                end
            end
            SDINITAPREF: begin
                if (tmr_done) begin
                    cmd_d    = AUTOREF;
                    ref_d    = ref_q + 4'd1;
                    tmr_load = 1'b1;
                    tmr_val  = RFC_LOAD_C;
                    if (ref_d == REF_LAST) begin
                        state_d = SDINITMRS;
                    end
                end
            end
            SDINITMRS: begin
                if (tmr_done) begin
                    cmd_d    = MODEREGSET;
                    addr_d   = MODE_ADDR;
                    tmr_load = 1'b1;
                    tmr_val  = MRD_LOAD_C;
`ifdef SDRAM_EMRS_EN
                    state_d  = SDINITEMRS;
`else
                    state_d  = SDINITIDLE;
`endif
                end
            end
`ifdef SDRAM_EMRS_EN
            SDINITEMRS: begin
                if (tmr_done) begin
                    cmd_d    = MODEREGSET;
                    ba_d     = BA_W'(EMRS_BA);
                    addr_d   = EMRS_VALUE;
                    tmr_load = 1'b1;
                    tmr_val  = MRD_LOAD_C;
                    state_d  = SDINITIDLE;
                end
            end
`endif
            SDINITIDLE: begin
                // The last MRD wait runs here before InitDone rises;
                // ReInit is only honoured once InitDone is high.
                if (done_q) begin
                    if (bus.ReInit) begin
                        done_d   = 1'b0;
                        busy_d   = 1'b1;
                        ref_d    = '0;
                        tmr_load = 1'b1;
                        tmr_val  = '0;
                        state_d  = SDINITPRECH;
                    end
                end else if (tmr_done) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: begin
                // Corrupted state: fall back to the reset condition
                state_d  = SDINITSTABLE;
                cke_d    = 1'b0;
                busy_d   = 1'b1;
                done_d   = 1'b0;
                ref_d    = '0;
                tmr_load = 1'b1;
                tmr_val  = '0;
            end
        endcase
    end

    // State and registered SDRAM outputs
    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            state_q <= SDINITSTABLE;
            cke_q   <= 1'b0;
            cmd_q   <= NOPC;
            addr_q  <= '0;
            ba_q    <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            ref_q   <= '0;
        end else begin
            state_q <= state_d;
            cke_q   <= cke_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            ba_q    <= ba_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ref_q   <= ref_d;
        end
    end

    assign bus.SdramCke  = cke_q;
    assign bus.SdramCmd  = cmd_q;
    assign bus.SdramAddr = addr_q;
    assign bus.SdramBa   = ba_q;
    assign bus.InitBusy  = busy_q;
    assign bus.InitDone  = done_q;
endmodule
